// File: rtl/wasm_pkg.sv
// Shared definitions for the WebAssembly operand-stack datapath.
//   TRAP_*       : 3-bit codes driven on the cpu trap bus
//   stk_state_e  : stack_sequencer control states
//   DATA_W_DEF   : default stack entry width (i32 values are zero-extended)
package wasm_pkg;

  localparam int DATA_W_DEF = 64;

  localparam logic [2:0] TRAP_NONE            = 3'd0;
  localparam logic [2:0] TRAP_STACK_UNDERFLOW = 3'd1;
  localparam logic [2:0] TRAP_STACK_OVERFLOW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_POP_WAIT,
    ST_EXEC,
    ST_PUSH,
    ST_REFILL,
    ST_TRAP
  } stk_state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack RAM, DEPTH x DATA_W, synchronous read, write-first.
//   clk     : clock
//   we_i    : write enable (address/data sampled on the same edge)
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after the address is presented;
//             on a write it returns the data being written
module stack_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// WebAssembly operand-stack sequencer. For each decoded instruction it pops
// up to three operands from the stack RAM (one read per cycle), offers them
// to the ALU, writes the ALU result back and keeps a top-of-stack view.
//   clk, reset            : clock, synchronous active-high reset
//   op_valid/op_ready     : instruction handshake from decode
//   op_pop, op_push       : operands to pop (0-3), push one result
//   opnd_valid, opnd_a..c : operands to ALU (deepest in opnd_a)
//   alu_valid, alu_res    : ALU result, sampled only while opnd_valid
//   result, result_empty  : top of stack view (0 / 1 when empty)
//   trap                  : 0 none, 1 underflow, 2 overflow (sticky to reset)
//   max_sp                : stack high-water mark, only when
//                           STACK_HIGHWATER_EN is defined
module stack_sequencer
  import wasm_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_pop,
  input  logic              op_push,
  output logic              opnd_valid,
  output logic [DATA_W-1:0] opnd_a,
  output logic [DATA_W-1:0] opnd_b,
  output logic [DATA_W-1:0] opnd_c,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] result,
  output logic              result_empty,
`ifdef STACK_HIGHWATER_EN
  output logic [ADDR_W:0]   max_sp,
`endif
  output logic [2:0]        trap
);

  stk_state_e        state_q, state_d;
  logic [ADDR_W:0]   sp_q, sp_d;
  logic [1:0]        pop_q, pop_d;
  logic              push_q, push_d;
  logic [1:0]        k_q, k_d;
  logic              rd_vld_q, rd_vld_d;
  logic [1:0]        rd_slot_q, rd_slot_d;
  logic              refill_rd_q, refill_rd_d;
  logic [DATA_W-1:0] opnd_q [3];
  logic [DATA_W-1:0] opnd_d [3];
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [2:0]        trap_q, trap_d;
`ifdef STACK_HIGHWATER_EN
  logic [ADDR_W:0]   max_sp_q, max_sp_d;
`endif

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W+1:0] sp_need;

  // Stack depth after the incoming op; one extra bit so sp==DEPTH plus a push
  // is still compared without wrapping.
  assign sp_need = {1'b0, sp_q} - (ADDR_W+2)'(op_pop) + (ADDR_W+2)'(op_push);

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pop_d       = pop_q;
    push_d      = push_q;
    k_d         = k_q;
    rd_vld_d    = 1'b0;
    rd_slot_d   = rd_slot_q;
    refill_rd_d = refill_rd_q;
    opnd_d      = opnd_q;
    alu_d       = alu_q;
    result_d    = result_q;
    trap_d      = trap_q;
`ifdef STACK_HIGHWATER_EN
    max_sp_d    = max_sp_q;
`endif
    ram_we      = 1'b0;
    ram_addr    = '0;
    op_ready    = 1'b0;

    // A read issued last cycle lands in its operand slot now.
    if (rd_vld_q) opnd_d[rd_slot_q] = ram_rdata;

    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          pop_d  = op_pop;
          push_d = op_push;
          k_d    = 2'd0;
          if ((ADDR_W+1)'(op_pop) > sp_q) begin
            trap_d  = TRAP_STACK_UNDERFLOW;
            state_d = ST_TRAP;
          end else if (sp_need > (ADDR_W+2)'(DEPTH)) begin
            trap_d  = TRAP_STACK_OVERFLOW;
            state_d = ST_TRAP;
          end else if (op_pop != 2'd0) begin
            state_d = ST_POP;
          end else if (op_push) begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_POP: begin
        // Top first: address sp-1-k fills slot pop-1-k.
        ram_addr  = sp_q[ADDR_W-1:0] - ADDR_W'(k_q) - ADDR_W'(1);
        rd_vld_d  = 1'b1;
        rd_slot_d = pop_q - 2'd1 - k_q;
        k_d       = k_q + 2'd1;
        if (k_q == pop_q - 2'd1) state_d = ST_POP_WAIT;
      end
      ST_POP_WAIT: begin
        sp_d    = sp_q - (ADDR_W+1)'(pop_q);
        state_d = push_q ? ST_EXEC : ST_REFILL;
      end
      ST_EXEC: begin
        if (alu_valid) begin
          alu_d   = alu_res;
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        ram_we   = ~reset;
        ram_addr = sp_q[ADDR_W-1:0];
        sp_d     = sp_q + (ADDR_W+1)'(1);
        result_d = alu_q;
`ifdef STACK_HIGHWATER_EN
        if (sp_d > max_sp_q) max_sp_d = sp_d;
`endif
        state_d  = ST_IDLE;
      end
      ST_REFILL: begin
        if (refill_rd_q) begin
          result_d    = ram_rdata;
          refill_rd_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (sp_q == '0) begin
          result_d = '0;
          state_d  = ST_IDLE;
        end else begin
          ram_addr    = sp_q[ADDR_W-1:0] - ADDR_W'(1);
          refill_rd_d = 1'b1;
        end
      end
      ST_TRAP: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sp_q        <= '0;
      rd_vld_q    <= 1'b0;
      refill_rd_q <= 1'b0;
      trap_q      <= TRAP_NONE;
      result_q    <= '0;
      opnd_q[0]   <= '0;
      opnd_q[1]   <= '0;
      opnd_q[2]   <= '0;
`ifdef STACK_HIGHWATER_EN
      max_sp_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      rd_vld_q    <= rd_vld_d;
      refill_rd_q <= refill_rd_d;
      trap_q      <= trap_d;
      result_q    <= result_d;
      opnd_q      <= opnd_d;
`ifdef STACK_HIGHWATER_EN
      max_sp_q    <= max_sp_d;
`endif
    end
  end

  // Op bookkeeping and the latched ALU result are only read after being
  // written for the current op, so they carry no reset.
  always_ff @(posedge clk) begin
    pop_q     <= pop_d;
    push_q    <= push_d;
    k_q       <= k_d;
    rd_slot_q <= rd_slot_d;
    alu_q     <= alu_d;
  end

  stack_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(alu_q),
    .rdata_o(ram_rdata)
  );

  assign opnd_valid   = (state_q == ST_EXEC);
  assign opnd_a       = opnd_q[0];
  assign opnd_b       = opnd_q[1];
  assign opnd_c       = opnd_q[2];
  assign result       = result_q;
  assign result_empty = (sp_q == '0);
  assign trap         = trap_q;
`ifdef STACK_HIGHWATER_EN
  assign max_sp       = max_sp_q;
`endif

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Controller for the WebAssembly operand stack. It sequences pop/compute/push for each instruction issued by the decode stage.
- Owns a single-port synchronous-read stack RAM and serialises pops into operand registers. It hands the operands to the ALU via a valid handshake, then writes back the ALU result.
- Maintains the top-of-stack view (result/result_empty) exported by cpu, and raises stack traps on the cpu trap bus.

Parameters:
- DEPTH, 1024, stack entries (power of two).
- ADDR_W, 10, log2(DEPTH).
- DATA_W, 64, entry width; i32 values are zero-extended.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  decode has an instruction.
- op_ready  output  1  sequencer can accept; op accepted when op_valid && op_ready.
- op_pop  input  2  operands to pop (0-3).
- op_push  input  1  instruction pushes one result.
- opnd_valid  output  1  operands stable for ALU.
- opnd_a / opnd_b / opnd_c  output  DATA_W each  operands; deepest popped value in opnd_a, top of stack in the highest-indexed used operand.
- alu_valid  input  1  ALU result valid (sampled only while opnd_valid).
- alu_res  input  DATA_W  ALU result.
- result  output  DATA_W  current top of stack (0 when empty).
- result_empty  output  1  stack pointer == 0.
- trap  output  3  0 NONE, 1 STACK_UNDERFLOW, 2 STACK_OVERFLOW.

Behaviour:
- Reset:
  - sp=0, state IDLE, op_ready=1, opnd_valid=0, operands=0, result=0, result_empty=1, trap=0.
  - Reset mid-operation aborts the op; no further RAM writes occur.
- States: IDLE, POP, POP_WAIT, EXEC, PUSH, REFILL, TRAP.
- IDLE:
  - op_ready=1.
  - On accept, check underflow first: op_pop > sp goes to TRAP with trap=1.
  - Then check overflow: sp - op_pop + op_push > DEPTH goes to TRAP with trap=2.
  - Otherwise: op_pop>0 goes to POP; op_pop==0 && op_push goes to EXEC; op_pop==0 && !op_push is a no-op and stays in IDLE.
- POP:
  - One RAM read per cycle at sp-1-k, for k = 0..op_pop-1, issued top first.
  - Read data returns one cycle later into the operand slot (op_pop-1-k).
  - After the last issue, go to POP_WAIT for one cycle to capture the final read.
- POP_WAIT: sp -= op_pop; next state is EXEC if op_push, else REFILL.
- EXEC:
  - opnd_valid=1 and operands held stable.
  - Stay until alu_valid, then latch alu_res and go to PUSH.
- PUSH:
  - Write mem[sp] = latched result; sp += 1; result = latched result; result_empty=0; go to IDLE.
- REFILL:
  - If sp==0: result=0, result_empty=1, go to IDLE.
  - Else read mem[sp-1], wait one cycle, load result, go to IDLE (2 cycles).
- TRAP: op_ready=0 and trap held until reset; stack contents frozen.
- Latency for op_pop=n>0 with push and alu_valid in the first EXEC cycle:
  - Accept at cycle T; EXEC at T+n+2; PUSH at T+n+3; op_ready high again at T+n+4.
  - For n=0: EXEC at T+1, op_ready high at T+3.
- Widths: sp is ADDR_W+1 bits, so sp==DEPTH is representable (full). Pushing at full traps; nothing wraps.
- op_valid is ignored while op_ready=0. Operands are undefined when opnd_valid=0, but hold their last values.

Optional Feature:
- STACK_HIGHWATER_EN defined: adds output max_sp (ADDR_W+1 bits).
  - Reset to 0; updated in PUSH cycles when the new sp exceeds it.
  - Not cleared by traps.
- Undefined: no port, no register; behaviour otherwise identical.

Decomposition:
- Shared package wasm_pkg:
  - trap code constants TRAP_NONE/TRAP_STACK_UNDERFLOW/TRAP_STACK_OVERFLOW (3-bit).
  - stack state enum.
  - DATA_W default.
- One sub-module, stack_ram: single-port, DEPTH x DATA_W, synchronous read, write-first; instantiated once.

Test Plan:
- Reset, then op(pop=0,push=1) with alu_res=1 -> result=1, result_empty=0, trap=0, op_ready high 3 cycles after accept.
- Push 7, push 5, then op(pop=2,push=1), ALU returns 2 -> opnd_a=7, opnd_b=5 in EXEC at T+4; result=2; sp=1.
- Push 1, 2, 3, then op(pop=3,push=1) -> opnd_a=1, opnd_b=2, opnd_c=3; push 3, 9, then op(pop=1,push=0) -> REFILL, result=3, result_empty=0.
- Empty stack, op(pop=1,push=1) -> trap=1, op_ready=0; further op_valid ignored; reset clears trap and result_empty=1.
- DEPTH=4 build, five pushes -> fifth traps with trap=2, result is the fourth value; with STACK_HIGHWATER_EN, max_sp=4.
- Hold alu_valid low 5 cycles in EXEC, assert reset in the 3rd -> next cycle op_ready=1, result_empty=1, no RAM write observed.
